// File: rtl/regfile_pkg.sv
// Shared sizing and types for the register file with pending-write scoreboard.
// Optional bypass build is selected with the REGFILE_BYPASS_EN macro (see regfile_scoreboard.sv).
package regfile_pkg;

  localparam int DEF_D_SIZE  = 32;
  localparam int DEF_R_COUNT = 8;
  localparam int DEF_PEND_W  = 2;

  // Address width for a given register count; never narrower than one bit.
  function automatic int addr_width(input int r_count);
    return (r_count < 2) ? 1 : $clog2(r_count);
  endfunction

  localparam int DEF_A_SIZE = addr_width(DEF_R_COUNT);
  localparam int PEND_MAX   = 2**DEF_PEND_W - 1;

  typedef logic [DEF_PEND_W-1:0] pend_t;
  typedef logic [DEF_A_SIZE-1:0] reg_addr_t;

endpackage

// File: rtl/pending_counter.sv
// Saturating up/down count of outstanding writes to one register; 1-cycle update latency.
// No backpressure: the issuer must not increment at max, underflow is flagged as a registered pulse.
module pending_counter #(
  parameter int PEND_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inc,
  input  logic              dec,
  output logic [PEND_W-1:0] count,
  output logic              underflow
);

  localparam logic [PEND_W-1:0] MAX = '1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count     <= '0;
      underflow <= 1'b0;
    end else begin
      // A simultaneous issue and write-back cancel out, even at zero.
      underflow <= dec & ~inc & (count == '0);
      if (inc && !dec && count != MAX)
        count <= count + PEND_W'(1);
      else if (dec && !inc && count != '0)
        count <= count - PEND_W'(1);
    end
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// Register file, 2 combinational read ports, 1 write-back port, per-register pending-write scoreboard.
// Reads 0-cycle, writes 1-cycle; issue_ready drops when the destination count saturates.
// Define REGFILE_BYPASS_EN to forward same-cycle write-back data to the read ports.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int D_SIZE  = DEF_D_SIZE,
  parameter int R_COUNT = DEF_R_COUNT,
  parameter int A_SIZE  = addr_width(R_COUNT),
  parameter int PEND_W  = DEF_PEND_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              issue_valid,
  input  logic              issue_dst_en,
  input  logic [A_SIZE-1:0] issue_dst,
  output logic              issue_ready,
  input  logic              wb_en,
  input  logic [A_SIZE-1:0] wb_dst,
  input  logic [D_SIZE-1:0] wb_data,
  input  logic [A_SIZE-1:0] source_1,
  input  logic [A_SIZE-1:0] source_2,
  output logic [D_SIZE-1:0] operand_1,
  output logic [D_SIZE-1:0] operand_2,
  output logic              src_1_busy,
  output logic              src_2_busy,
  output logic              hazard,
  output logic              err_underflow
);

  localparam logic [PEND_W-1:0] CNT_MAX = '1;

  logic [D_SIZE-1:0]  regs [R_COUNT];
  logic [PEND_W-1:0]  pend [R_COUNT];
  logic [R_COUNT-1:0] uflow;
  logic [R_COUNT-1:0] inc;
  logic [R_COUNT-1:0] dec;
  logic               wb_hits_issue;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < R_COUNT; r++)
        regs[r] <= '0;
    end else if (wb_en) begin
      regs[wb_dst] <= wb_data;
    end
  end

  // A write-back to the saturated destination frees a slot in the same cycle.
  assign wb_hits_issue = wb_en && (wb_dst == issue_dst);
  assign issue_ready   = !(issue_dst_en && pend[issue_dst] == CNT_MAX) || wb_hits_issue;

  genvar g;
  generate
    for (g = 0; g < R_COUNT; g++) begin : g_pend
      assign inc[g] = issue_valid && issue_dst_en && issue_ready && (issue_dst == A_SIZE'(g));
      assign dec[g] = wb_en && (wb_dst == A_SIZE'(g));

      pending_counter #(
        .PEND_W (PEND_W)
      ) u_cnt (
        .clk       (clk),
        .rst_n     (rst_n),
        .inc       (inc[g]),
        .dec       (dec[g]),
        .count     (pend[g]),
        .underflow (uflow[g])
      );
    end
  endgenerate

  assign err_underflow = |uflow;

`ifdef REGFILE_BYPASS_EN
  logic hit_1;
  logic hit_2;

  assign hit_1 = wb_en && (wb_dst == source_1);
  assign hit_2 = wb_en && (wb_dst == source_2);

  // The write resolving this cycle no longer counts against the reader.
  always_comb begin
    operand_1  = hit_1 ? wb_data : regs[source_1];
    operand_2  = hit_2 ? wb_data : regs[source_2];
    src_1_busy = hit_1 ? (pend[source_1] > PEND_W'(1)) : (pend[source_1] != '0);
    src_2_busy = hit_2 ? (pend[source_2] > PEND_W'(1)) : (pend[source_2] != '0);
  end
`else
  always_comb begin
    operand_1  = regs[source_1];
    operand_2  = regs[source_2];
    src_1_busy = (pend[source_1] != '0);
    src_2_busy = (pend[source_2] != '0);
  end
`endif

  assign hazard = src_1_busy | src_2_busy;

endmodule
